lfsr_checker: RTL and testbench

LFSR_CHECKER -- requirements
Module: lfsr_checker

---
 rtl/lfsr_pkg.sv | 20 ++
 rtl/lfsr_checker_sat_counter.sv | 24 ++
 rtl/lfsr_checker.sv | 122 ++++++++++++
 tb/tb_lfsr_checker.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the PRBS lock checker: LFSR geometry, feedback taps
// and the two-state lock machine encoding.
package lfsr_pkg;

    localparam int LFSR_W = 8;

    // Feedback taps 8,6,5,4 expressed as a mask over hist[7:0] (hist[7] newest).
    localparam logic [LFSR_W-1:0] TAP_MASK = 8'b1011_1000;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Next bit the upstream generator will emit, given its last LFSR_W bits.
    function automatic logic lfsr_pred(input logic [LFSR_W-1:0] h);
        return ^(h & TAP_MASK);
    endfunction

endpackage

// File: rtl/lfsr_checker_sat_counter.sv
// Saturating up-counter with synchronous clear. A clear in the same cycle as
// an increment leaves the count at 1 so that event is not lost.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    // Count events, hold at all-ones, clear on request.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= {{(WIDTH-1){1'b0}}, inc};
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/lfsr_checker.sv
// PRBS-8 lock checker. In SEARCH the received bits fill the history and each
// bit is compared with the LFSR prediction; enough consecutive good
// predictions declare lock. In LOCKED the history free-runs on its own
// predictions (flywheel), so a single corrupted input bit produces exactly
// one error instead of being re-injected into later predictions. Too many
// errors inside one window drop back to SEARCH.
//
//   state  | meaning
//   SEARCH | filling history and counting consecutive correct predictions
//   LOCKED | flywheel running, errors counted per window and in err_count
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_MATCHES = 16,
    parameter int UNLOCK_ERRS  = 4,
    parameter int WINDOW       = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_bit,
    input  logic              clr_cnt,
    output logic              locked,
    output logic              err_pulse,
    output logic [15:0]       err_count,
    output logic [LFSR_W-1:0] hist
);

    localparam int WIN_W = $clog2(WINDOW);
    localparam int ERR_W = WIN_W + 1;

    localparam logic [7:0]       MATCH_LAST = 8'(LOCK_MATCHES - 1);
    localparam logic [WIN_W-1:0] WIN_LAST   = WIN_W'(WINDOW - 1);
    localparam logic [ERR_W-1:0] ERR_LIMIT  = ERR_W'(UNLOCK_ERRS);

    state_t           state;
    logic [3:0]       fill;
    logic [7:0]       match_cnt;
    logic [WIN_W-1:0] win_cnt;
    logic [ERR_W-1:0] win_errs;

    logic             pred;
    logic             match_ok;
    logic             bit_err;
    logic [ERR_W-1:0] win_errs_next;

    // Prediction and per-bit qualifiers derived from the current history.
    always_comb begin
        pred          = lfsr_pred(hist);
        match_ok      = (fill == 4'd8) && (hist != '0) && (in_bit == pred);
        bit_err       = in_valid && (state == LOCKED) && (in_bit != pred);
        win_errs_next = win_errs + ERR_W'(bit_err);
    end

    // Lock state machine, history shifter and window bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= SEARCH;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            hist      <= '0;
            fill      <= '0;
            match_cnt <= '0;
            win_cnt   <= '0;
            win_errs  <= '0;
        end else begin
            err_pulse <= bit_err;
            if (in_valid) begin
                case (state)
                    SEARCH: begin
                        hist <= {in_bit, hist[LFSR_W-1:1]};
                        if (fill != 4'd8) begin
                            fill <= fill + 4'd1;
                        end
                        if (match_ok) begin
                            if (match_cnt == MATCH_LAST) begin
                                state     <= LOCKED;
                                locked    <= 1'b1;
                                match_cnt <= '0;
                                win_cnt   <= '0;
                                win_errs  <= '0;
                            end else begin
                                match_cnt <= match_cnt + 8'd1;
                            end
                        end else begin
                            match_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        hist <= {pred, hist[LFSR_W-1:1]};
                        // The closing bit's error still belongs to the closing window.
                        if (win_errs_next >= ERR_LIMIT) begin
                            state     <= SEARCH;
                            locked    <= 1'b0;
                            fill      <= '0;
                            match_cnt <= '0;
                            win_cnt   <= '0;
                            win_errs  <= '0;
                        end else if (win_cnt == WIN_LAST) begin
                            win_cnt  <= '0;
                            win_errs <= '0;
                        end else begin
                            win_cnt  <= win_cnt + {{(WIN_W-1){1'b0}}, 1'b1};
                            win_errs <= win_errs_next;
                        end
                    end
                endcase
            end
        end
    end

    sat_counter #(
        .WIDTH(16)
    ) u_err_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (bit_err),
        .clr  (clr_cnt),
        .count(err_count)
    );

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: two instances (default parameters, and a
// saturation instance with UNLOCK_ERRS=WINDOW) checked every cycle against a
// behavioural model, plus literal expectations at key points.
module tb_lfsr_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance
    logic        rst_m = 1'b0, valid_m = 1'b0, bit_m = 1'b0, clr_m = 1'b0;
    logic        locked_m, pulse_m;
    logic [15:0] cnt_m;
    logic [7:0]  hist_m;

    // saturation instance
    logic        rst_s = 1'b0, valid_s = 1'b0, bit_s = 1'b0, clr_s = 1'b0;
    logic        locked_s, pulse_s;
    logic [15:0] cnt_s;
    logic [7:0]  hist_s;

    lfsr_checker #(.LOCK_MATCHES(16), .UNLOCK_ERRS(4), .WINDOW(64)) dut_m (
        .clk(clk), .rst(rst_m), .in_valid(valid_m), .in_bit(bit_m), .clr_cnt(clr_m),
        .locked(locked_m), .err_pulse(pulse_m), .err_count(cnt_m), .hist(hist_m)
    );

    lfsr_checker #(.LOCK_MATCHES(16), .UNLOCK_ERRS(64), .WINDOW(64)) dut_s (
        .clk(clk), .rst(rst_s), .in_valid(valid_s), .in_bit(bit_s), .clr_cnt(clr_s),
        .locked(locked_s), .err_pulse(pulse_s), .err_count(cnt_s), .hist(hist_s)
    );

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit       m_init[2]   = '{0, 0};
    bit       m_locked[2];
    bit       m_pulse[2];
    bit [7:0] m_hist[2];
    int       m_fill[2], m_match[2], m_wpos[2], m_werr[2], m_cnt[2];

    task automatic model_step(input int k, input logic r, input logic v, input logic b,
                              input logic c, input int lm, input int ue, input int w);
        bit p, e, q;
        if (!r) begin
            m_init[k] = 1; m_locked[k] = 0; m_pulse[k] = 0; m_hist[k] = 0;
            m_fill[k] = 0; m_match[k] = 0; m_wpos[k] = 0; m_werr[k] = 0; m_cnt[k] = 0;
            return;
        end
        if (!m_init[k]) return;
        e = 0;
        if (v) begin
            p = m_hist[k][7] ^ m_hist[k][5] ^ m_hist[k][4] ^ m_hist[k][3];
            if (!m_locked[k]) begin
                q = (m_fill[k] == 8) && (m_hist[k] != 0) && (b == p);
                m_hist[k] = {b, m_hist[k][7:1]};
                if (m_fill[k] < 8) m_fill[k]++;
                if (q) begin
                    m_match[k]++;
                    if (m_match[k] == lm) begin
                        m_locked[k] = 1; m_match[k] = 0; m_wpos[k] = 0; m_werr[k] = 0;
                    end
                end else begin
                    m_match[k] = 0;
                end
            end else begin
                e = (b != p);
                m_hist[k] = {p, m_hist[k][7:1]};
                m_werr[k] += int'(e);
                m_wpos[k]++;
                if (m_werr[k] >= ue) begin
                    m_locked[k] = 0; m_fill[k] = 0; m_match[k] = 0; m_wpos[k] = 0; m_werr[k] = 0;
                end else if (m_wpos[k] == w) begin
                    m_wpos[k] = 0; m_werr[k] = 0;
                end
            end
        end
        m_pulse[k] = e;
        if (c) m_cnt[k] = e ? 1 : 0;
        else if (e && m_cnt[k] < 65535) m_cnt[k]++;
    endtask

    // Advance both models on the same edge the DUTs sample their inputs.
    always @(posedge clk) begin
        model_step(0, rst_m, valid_m, bit_m, clr_m, 16, 4, 64);
        model_step(1, rst_s, valid_s, bit_s, clr_s, 16, 64, 64);
    end

    // Compare every output of both instances against the model each cycle.
    always @(negedge clk) begin
        if (m_init[0]) begin
            check("m.locked",    int'(locked_m), int'(m_locked[0]));
            check("m.err_pulse", int'(pulse_m),  int'(m_pulse[0]));
            check("m.err_count", int'(cnt_m),    m_cnt[0]);
            check("m.hist",      int'(hist_m),   int'(m_hist[0]));
        end
        if (m_init[1]) begin
            check("s.locked",    int'(locked_s), int'(m_locked[1]));
            check("s.err_pulse", int'(pulse_s),  int'(m_pulse[1]));
            check("s.err_count", int'(cnt_s),    m_cnt[1]);
            check("s.hist",      int'(hist_s),   int'(m_hist[1]));
        end
    end

    // ---------------- upstream generators ----------------
    logic [7:0] gen_m = 8'h80;
    logic [7:0] gen_s = 8'h80;
    int nbits   = 0;
    int lock_at = 0;

    task automatic drive_m(input logic r, input logic v, input logic b, input logic c);
        rst_m = r; valid_m = v; bit_m = b; clr_m = c;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic good_m(input logic flip, input logic c);
        logic b;
        b = gen_m[7] ^ gen_m[5] ^ gen_m[4] ^ gen_m[3];
        gen_m = {b, gen_m[7:1]};
        drive_m(1'b1, 1'b1, b ^ flip, c);
        nbits++;
    endtask

    task automatic drive_s(input logic r, input logic v, input logic b, input logic c);
        rst_s = r; valid_s = v; bit_s = b; clr_s = c;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic good_s(input logic flip, input logic c);
        logic b;
        b = gen_s[7] ^ gen_s[5] ^ gen_s[4] ^ gen_s[3];
        gen_s = {b, gen_s[7:1]};
        drive_s(1'b1, 1'b1, b ^ flip, c);
    endtask

    task automatic align_m();
        while (((nbits - lock_at) % 64) != 0) good_m(1'b0, 1'b0);
    endtask

    // ---------------- main instance sequence ----------------
    task automatic run_main();
        int j;
        @(negedge clk);
        drive_m(1'b0, 1'b1, 1'b1, 1'b1);
        drive_m(1'b0, 1'b0, 1'b0, 1'b0);
        check("reset locked", int'(locked_m), 0);
        check("reset err_count", int'(cnt_m), 0);
        check("reset hist", int'(hist_m), 0);

        // acquisition from a clean PRBS seeded 8'h80
        for (int i = 1; i <= 1000; i++) begin
            good_m(1'b0, 1'b0);
            if (i == 8)  check("hist after fill", int'(hist_m), 8'hB3);
            if (i == 23) check("not locked at bit 23", int'(locked_m), 0);
            if (i == 24) begin
                check("locked at bit 24", int'(locked_m), 1);
                lock_at = nbits;
            end
        end
        check("clean 1000 err_count", int'(cnt_m), 0);

        // single flipped bit: one pulse, no multiplication
        good_m(1'b1, 1'b0);
        check("single flip pulse", int'(pulse_m), 1);
        check("single flip count", int'(cnt_m), 1);
        good_m(1'b0, 1'b0);
        check("pulse one cycle", int'(pulse_m), 0);
        for (int i = 0; i < 20; i++) good_m(1'b0, 1'b0);
        check("single flip count held", int'(cnt_m), 1);
        check("single flip still locked", int'(locked_m), 1);
        good_m(1'b0, 1'b1);
        check("clr alone", int'(cnt_m), 0);

        // four errors inside one window unlock
        for (int i = 0; i < 64; i++) good_m(1'b0, 1'b0);
        align_m();
        for (j = 0; j < 16; j++) begin
            good_m(1'((j % 5) == 0), 1'b0);
            if (j == 14) check("locked after 3 errs", int'(locked_m), 1);
        end
        check("unlock after 4th err", int'(locked_m), 0);
        check("err_count after unlock", int'(cnt_m), 4);

        // relock from retained history
        for (int i = 1; i <= 24; i++) begin
            good_m(1'b0, 1'b0);
            if (i == 23) check("relock not yet", int'(locked_m), 0);
        end
        check("relock after 24", int'(locked_m), 1);
        lock_at = nbits;

        // three errors per window, and six straddling a boundary
        for (int i = 0; i < 192; i++) good_m(1'(((i % 64) == 10) || ((i % 64) == 20) || ((i % 64) == 30)), 1'b0);
        for (int i = 0; i < 128; i++) good_m(1'((i >= 61) && (i <= 66)), 1'b0);
        check("3 per window stays locked", int'(locked_m), 1);
        check("err_count after windows", int'(cnt_m), 19);

        // idle cycles change nothing
        for (int i = 0; i < 10; i++) drive_m(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
        check("idle pulse", int'(pulse_m), 0);
        check("idle count", int'(cnt_m), 19);

        // all-zero stream never locks
        drive_m(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 200; i++) drive_m(1'b1, 1'b1, 1'b0, 1'b0);
        check("zero stream unlocked", int'(locked_m), 0);
        check("zero stream hist", int'(hist_m), 0);

        // lock, take an error, then reset mid-lock with random inputs
        for (int i = 0; i < 24; i++) good_m(1'b0, 1'b0);
        check("lock before reset", int'(locked_m), 1);
        good_m(1'b1, 1'b0);
        drive_m(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        check("mid-lock reset locked", int'(locked_m), 0);
        check("mid-lock reset pulse", int'(pulse_m), 0);
        check("mid-lock reset count", int'(cnt_m), 0);
        check("mid-lock reset hist", int'(hist_m), 0);
        for (int i = 1; i <= 24; i++) begin
            for (int k = $urandom_range(0, 2); k > 0; k--)
                drive_m(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
            good_m(1'b0, 1'b0);
            if (i == 23) check("post-reset not yet", int'(locked_m), 0);
        end
        check("post-reset relock", int'(locked_m), 1);
    endtask

    // ---------------- saturation instance sequence ----------------
    task automatic run_sat();
        @(negedge clk);
        drive_s(1'b0, 1'b0, 1'b0, 1'b0);
        drive_s(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 24; i++) good_s(1'b0, 1'b0);
        check("sat locked", int'(locked_s), 1);
        for (int i = 0; i < 66700; i++) good_s(1'((i % 64) != 63), 1'b0);
        check("sat err_count", int'(cnt_s), 16'hFFFF);
        check("sat still locked", int'(locked_s), 1);
        good_s(1'b1, 1'b0);
        check("sat held", int'(cnt_s), 16'hFFFF);
        good_s(1'b1, 1'b1);
        check("clr with err", int'(cnt_s), 1);
        good_s(1'b0, 1'b1);
        check("sat clr alone", int'(cnt_s), 0);
    endtask

    initial begin
        fork
            run_main();
            run_sat();
        join
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
